// File: rtl/float_to_fixed_conv.sv
// IEEE 754 single-precision to unsigned Q16.16 magnitude plus sign, with a
// bit-serial alignment shifter and a valid/ready handshake on both sides.
module float_to_fixed_conv (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] float_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fixed_out,
   output logic        sign_out,
   output logic [3:0]  flags
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        left_q, left_d;
   logic        sign_q, sign_d;
   logic [3:0]  flags_q, flags_d;

   logic [7:0]  exp_s;
   logic [22:0] man_s;
   logic [7:0]  dist_s;

   assign exp_s = float_in[30:23];
   assign man_s = float_in[22:0];

   // Distance from the Q16.16 binary point: the operand sits at 2^(exp-134).
   always_comb begin
      if (exp_s >= 8'd134) begin
         dist_s = exp_s - 8'd134;
      end else begin
         dist_s = 8'd134 - exp_s;
      end
   end

   // Next-state, datapath and flag logic.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      sign_d  = sign_q;
      flags_d = flags_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d  = float_in[31];
               flags_d = 4'b0000;
               state_d = DONE;
               if (exp_s == 8'd255 && man_s != 23'd0) begin
                  acc_d   = 32'd0;
                  flags_d = 4'b1000;
               end else if (exp_s == 8'd255 || exp_s >= 8'd143) begin
                  acc_d   = 32'hFFFF_FFFF;
                  flags_d = 4'b0100;
               end else if (exp_s == 8'd0) begin
                  acc_d   = 32'd0;
                  flags_d = {2'b00, (man_s != 23'd0), 1'b0};
               end else if (exp_s <= 8'd110) begin
                  acc_d   = 32'd0;
                  flags_d = 4'b0011;
               end else begin
                  acc_d   = {8'd0, 1'b1, man_s};
                  cnt_d   = dist_s[4:0];
                  left_d  = (exp_s > 8'd134);
                  state_d = ALIGN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ALIGN: begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
               if (left_q) begin
                  acc_d = {acc_q[30:0], 1'b0};
               end else begin
                  acc_d = {1'b0, acc_q[31:1]};
                  // Sticky inexact: any 1 dropped off the bottom is lost precision.
                  flags_d[0] = flags_q[0] | acc_q[0];
               end
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= 32'd0;
         cnt_q   <= 5'd0;
         left_q  <= 1'b0;
         sign_q  <= 1'b0;
         flags_q <= 4'd0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         sign_q  <= sign_d;
         flags_q <= flags_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign fixed_out = acc_q;
   assign sign_out  = sign_q;
   assign flags     = flags_q;

endmodule
